// File: rtl/ili9341_spi_driver_pkg.sv
// Shared definitions for the ILI9341 SPI driver: panel command set, FSM states
// and the power-up command ROM.
package ili9341_spi_driver_pkg;

    localparam logic [7:0] SWRESET = 8'h01;
    localparam logic [7:0] SLPOUT  = 8'h11;
    localparam logic [7:0] COLMOD  = 8'h3A;
    localparam logic [7:0] MADCTL  = 8'h36;
    localparam logic [7:0] DISPON  = 8'h29;
    localparam logic [7:0] CASET   = 8'h2A;
    localparam logic [7:0] PASET   = 8'h2B;
    localparam logic [7:0] RAMWR   = 8'h2C;

    localparam logic [7:0] COLMOD_RGB565 = 8'h55;
    localparam logic [7:0] MADCTL_BGR    = 8'h48;

    localparam int INIT_LEN = 7;
    localparam int WIN_LEN  = 11;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_DELAY,
        ST_WINDOW,
        ST_STREAM,
        ST_PAUSE
    } state_t;

    typedef enum logic [1:0] {
        DLY_NONE,
        DLY_SWRESET,
        DLY_SLPOUT
    } dly_sel_t;

    typedef struct packed {
        logic     dc;
        logic [7:0] data;
        dly_sel_t dly;
    } rom_entry_t;

    function automatic rom_entry_t init_rom(input logic [2:0] idx);
        case (idx)
            3'd0:    return '{1'b0, SWRESET, DLY_SWRESET};
            3'd1:    return '{1'b0, SLPOUT, DLY_SLPOUT};
            3'd2:    return '{1'b0, COLMOD, DLY_NONE};
            3'd3:    return '{1'b1, COLMOD_RGB565, DLY_NONE};
            3'd4:    return '{1'b0, MADCTL, DLY_NONE};
            3'd5:    return '{1'b1, MADCTL_BGR, DLY_NONE};
            default: return '{1'b0, DISPON, DLY_NONE};
        endcase
    endfunction

endpackage

// File: rtl/spi_byte_tx.sv
// Mode-0 SPI byte shifter: one start pulse sends 8 bits MSB first in 16 cycles;
// done marks the last cycle so a new start there gives back-to-back bytes.
module spi_byte_tx (
    input  logic       clk_out,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    input  logic       dc_in,
    output logic       sck,
    output logic       mosi,
    output logic       dc,
    output logic       busy,
    output logic       done
);

    logic [3:0] cnt;
    logic [6:0] shreg;

    assign done = busy && (cnt == 4'd15);

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            busy <= 1'b0;
            cnt  <= 4'd0;
            sck  <= 1'b0;
            mosi <= 1'b0;
            dc   <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            cnt  <= 4'd0;
            sck  <= 1'b0;
            mosi <= data_in[7];
            dc   <= dc_in;
        end else if (busy) begin
            cnt <= cnt + 4'd1;
            if (done) begin
                busy <= 1'b0;
                sck  <= 1'b0;
            end else if (!cnt[0]) begin
                sck <= 1'b1;
            end else begin
                // falling SCK edge is where the next bit is presented
                sck  <= 1'b0;
                mosi <= shreg[6];
            end
        end
    end

    always_ff @(posedge clk_out) begin
        if (start) begin
            shreg <= data_in[6:0];
        end else if (busy && cnt[0] && !done) begin
            shreg <= {shreg[5:0], 1'b0};
        end
    end

endmodule

// File: rtl/ili9341_spi_driver.sv
// ILI9341 4-wire SPI driver: power-up command ROM, full-screen address window,
// then RGB565 pixel streaming paced by the data_clk request strobe.
module ili9341_spi_driver
    import ili9341_spi_driver_pkg::*;
#(
    parameter int CLK_HZ      = 62_500_000,
    parameter int WIDTH       = 240,
    parameter int HEIGHT      = 240,
    parameter int SWRESET_DLY = CLK_HZ / 200,
    parameter int SLPOUT_DLY  = CLK_HZ / 8
) (
    input  logic        clk_out,
    input  logic        rst,
    input  logic        frame_done,
    input  logic [15:0] input_data,
    output logic        spi_mosi,
    output logic        spi_sck,
    output logic        spi_cs,
    output logic        spi_dc,
    output logic        data_clk
);

    localparam int NPIX  = WIDTH * HEIGHT;
    localparam int PIX_W = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [15:0]      W_MAX       = 16'(WIDTH - 1);
    localparam logic [15:0]      H_MAX       = 16'(HEIGHT - 1);
    localparam logic [PIX_W-1:0] PIX_LAST    = PIX_W'(NPIX - 1);
    localparam logic [31:0]      SWRESET_CNT = 32'(SWRESET_DLY);
    localparam logic [31:0]      SLPOUT_CNT  = 32'(SLPOUT_DLY);
    localparam logic [2:0]       INIT_LAST   = 3'(INIT_LEN - 1);
    localparam logic [3:0]       WIN_LAST    = 4'(WIN_LEN - 1);

    // {dc, byte} of the address-window sequence
    function automatic logic [8:0] win_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    return {1'b0, CASET};
            4'd3:    return {1'b1, W_MAX[15:8]};
            4'd4:    return {1'b1, W_MAX[7:0]};
            4'd5:    return {1'b0, PASET};
            4'd8:    return {1'b1, H_MAX[15:8]};
            4'd9:    return {1'b1, H_MAX[7:0]};
            4'd10:   return {1'b0, RAMWR};
            default: return {1'b1, 8'h00};
        endcase
    endfunction

    state_t           state, state_n;
    logic [2:0]       rom_idx, rom_idx_n;
    logic [3:0]       win_idx, win_idx_n;
    logic [31:0]      delay_cnt, delay_cnt_n;
    logic             lo_byte, lo_byte_n;
    logic [PIX_W-1:0] pix_cnt, pix_cnt_n;
    logic [7:0]       pix_lo;
    logic             pix_start;
    logic             cs_n, data_clk_n;
    logic             tx_start, tx_dc, tx_busy, tx_done;
    logic [7:0]       tx_byte;
    rom_entry_t       cur_ent, nxt_ent;

    assign cur_ent = init_rom(rom_idx);
    assign nxt_ent = init_rom(rom_idx + 3'd1);

    spi_byte_tx u_tx (
        .clk_out (clk_out),
        .rst     (rst),
        .start   (tx_start),
        .data_in (tx_byte),
        .dc_in   (tx_dc),
        .sck     (spi_sck),
        .mosi    (spi_mosi),
        .dc      (spi_dc),
        .busy    (tx_busy),
        .done    (tx_done)
    );

    always_comb begin
        state_n     = state;
        rom_idx_n   = rom_idx;
        win_idx_n   = win_idx;
        delay_cnt_n = delay_cnt;
        lo_byte_n   = lo_byte;
        pix_cnt_n   = pix_cnt;
        cs_n        = spi_cs;
        data_clk_n  = 1'b0;
        tx_start    = 1'b0;
        tx_dc       = 1'b0;
        tx_byte     = 8'h00;
        pix_start   = 1'b0;

        unique case (state)
            ST_INIT: begin
                tx_dc   = cur_ent.dc;
                tx_byte = cur_ent.data;
                // a burst opens with one cycle of CS low before the first bit
                if (spi_cs) begin
                    cs_n = 1'b0;
                end else if (!tx_busy) begin
                    tx_start = 1'b1;
                end else if (tx_done) begin
                    if (cur_ent.dly != DLY_NONE) begin
                        state_n     = ST_DELAY;
                        rom_idx_n   = rom_idx + 3'd1;
                        delay_cnt_n = (cur_ent.dly == DLY_SWRESET) ? SWRESET_CNT : SLPOUT_CNT;
                    end else if (rom_idx == INIT_LAST) begin
                        state_n            = ST_WINDOW;
                        win_idx_n          = 4'd0;
                        tx_start           = 1'b1;
                        {tx_dc, tx_byte}   = win_entry(4'd0);
                    end else begin
                        rom_idx_n = rom_idx + 3'd1;
                        tx_start  = 1'b1;
                        tx_dc     = nxt_ent.dc;
                        tx_byte   = nxt_ent.data;
                    end
                end
            end
            ST_DELAY: begin
                cs_n = 1'b1;
                if (delay_cnt == 32'd0) begin
                    state_n = ST_INIT;
                end else begin
                    delay_cnt_n = delay_cnt - 32'd1;
                end
            end
            ST_WINDOW: begin
                {tx_dc, tx_byte} = win_entry(win_idx);
                if (spi_cs) begin
                    cs_n = 1'b0;
                end else if (!tx_busy) begin
                    tx_start = 1'b1;
                end else if (tx_done) begin
                    if (win_idx == WIN_LAST) begin
                        state_n = ST_STREAM;
                    end else begin
                        win_idx_n        = win_idx + 4'd1;
                        tx_start         = 1'b1;
                        {tx_dc, tx_byte} = win_entry(win_idx + 4'd1);
                    end
                end
            end
            ST_STREAM: begin
                tx_dc   = 1'b1;
                tx_byte = input_data[15:8];
                // frame_done is only honoured once the low byte has finished
                if (!tx_busy) begin
                    pix_start = 1'b1;
                end else if (tx_done) begin
                    if (!lo_byte) begin
                        tx_start  = 1'b1;
                        tx_byte   = pix_lo;
                        lo_byte_n = 1'b1;
                    end else if (frame_done) begin
                        state_n = ST_PAUSE;
                    end else begin
                        pix_start = 1'b1;
                    end
                end
                if (pix_start) begin
                    tx_start   = 1'b1;
                    data_clk_n = 1'b1;
                    lo_byte_n  = 1'b0;
                    pix_cnt_n  = (pix_cnt == PIX_LAST) ? '0 : pix_cnt + 1'b1;
                end
            end
            ST_PAUSE: begin
                cs_n = 1'b1;
                if (!frame_done) begin
                    state_n   = ST_WINDOW;
                    win_idx_n = 4'd0;
                    pix_cnt_n = '0;
                end
            end
            default: state_n = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_out) begin
        if (!rst) begin
            state     <= ST_INIT;
            rom_idx   <= 3'd0;
            win_idx   <= 4'd0;
            delay_cnt <= 32'd0;
            lo_byte   <= 1'b0;
            pix_cnt   <= '0;
            spi_cs    <= 1'b1;
            data_clk  <= 1'b0;
        end else begin
            state     <= state_n;
            rom_idx   <= rom_idx_n;
            win_idx   <= win_idx_n;
            delay_cnt <= delay_cnt_n;
            lo_byte   <= lo_byte_n;
            pix_cnt   <= pix_cnt_n;
            spi_cs    <= cs_n;
            data_clk  <= data_clk_n;
        end
    end

    // the high byte goes straight to the shifter; the low byte waits here
    always_ff @(posedge clk_out) begin
        if (pix_start) begin
            pix_lo <= input_data[7:0];
        end
    end

endmodule

// File: tb/tb_ili9341_spi_driver.sv
// Bench for ili9341_spi_driver: decodes the SPI pins into {dc,byte} records and
// compares them with the command list and the pixel values offered upstream.
module tb_ili9341_spi_driver;

    localparam int W = 240;
    localparam int H = 240;
    localparam int DLY = 10;

    logic        clk_out = 1'b0;
    logic        rst = 1'b0;
    logic        frame_done = 1'b0;
    logic [15:0] input_data = 16'hF800;
    logic        spi_mosi, spi_sck, spi_cs, spi_dc, data_clk;

    int n_assert = 0;
    int n_fail = 0;
    int mode = 0;

    always #5 clk_out = ~clk_out;

    ili9341_spi_driver #(
        .WIDTH(W), .HEIGHT(H), .SWRESET_DLY(DLY), .SLPOUT_DLY(DLY)
    ) dut (
        .clk_out    (clk_out),
        .rst        (rst),
        .frame_done (frame_done),
        .input_data (input_data),
        .spi_mosi   (spi_mosi),
        .spi_sck    (spi_sck),
        .spi_cs     (spi_cs),
        .spi_dc     (spi_dc),
        .data_clk   (data_clk)
    );

    // upstream pixel source: the value present at each strobe is the pixel owed
    logic [15:0] exp_pix[$];
    always @(posedge data_clk) begin
        exp_pix.push_back(input_data);
        if (mode != 0) input_data = input_data + 16'($urandom_range(1, 255));
    end

    // pin decoder
    int          cyc = 0, nbytes = 0, bitcnt = 0, n_dclk = 0, dclk_wide = 0;
    int          cs_high_total = 0, cs_run = 0;
    logic [7:0]  sh = 8'h00;
    logic        sck_prev = 1'b0, dclk_prev = 1'b0, cs_prev = 1'b1;
    logic [8:0]  rx[0:2047];
    int          dclk_t[0:2047];
    int          cs_run_at[0:2047];

    always @(negedge clk_out) begin
        cyc++;
        if (spi_cs) begin
            cs_high_total++;
            cs_run++;
        end else begin
            if (cs_prev && nbytes < 2048) cs_run_at[nbytes] = cs_run;
            cs_run = 0;
        end
        if (data_clk) begin
            if (n_dclk < 2048) dclk_t[n_dclk] = cyc;
            n_dclk++;
            if (dclk_prev) dclk_wide++;
        end
        if (!rst || spi_cs) begin
            bitcnt = 0;
        end else if (spi_sck && !sck_prev) begin
            sh = {sh[6:0], spi_mosi};
            bitcnt++;
            if (bitcnt == 8) begin
                if (nbytes < 2048) rx[nbytes] = {spi_dc, sh};
                nbytes++;
                bitcnt = 0;
            end
        end
        sck_prev  = spi_sck;
        dclk_prev = data_clk;
        cs_prev   = spi_cs;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_bytes(input int target, input int budget, input string tag);
        int k = 0;
        while (nbytes < target && k < budget) begin
            @(negedge clk_out);
            k++;
        end
        n_assert++;
        assert (nbytes >= target) else begin
            n_fail++;
            $error("FAIL %s: observed %0d bytes, expected at least %0d", tag, nbytes, target);
        end
    endtask

    task automatic wait_pin(input logic want_cs, input int budget, input string tag);
        int k = 0;
        while (((want_cs && spi_cs !== 1'b1) || (!want_cs && data_clk !== 1'b1)) && k < budget) begin
            @(negedge clk_out);
            k++;
        end
        n_assert++;
        assert (k < budget) else begin
            n_fail++;
            $error("FAIL %s: observed timeout after %0d cycles, expected event", tag, k);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cs"},   32'(spi_cs),   32'd1);
        check({tag, "_sck"},  32'(spi_sck),  32'd0);
        check({tag, "_mosi"}, 32'(spi_mosi), 32'd0);
        check({tag, "_dc"},   32'(spi_dc),   32'd0);
        check({tag, "_dclk"}, 32'(data_clk), 32'd0);
    endtask

    logic [8:0] init_q[$] = '{9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h029};
    logic [8:0] win_q[$];

    initial begin
        int base_cs, d_snap, pb, npix, rb;

        // window bytes derived from the geometry: column range then row range
        win_q.push_back({1'b0, 8'h2A});
        win_q.push_back(9'h100); win_q.push_back(9'h100);
        win_q.push_back({1'b1, 8'((W - 1) / 256)}); win_q.push_back({1'b1, 8'((W - 1) % 256)});
        win_q.push_back({1'b0, 8'h2B});
        win_q.push_back(9'h100); win_q.push_back(9'h100);
        win_q.push_back({1'b1, 8'((H - 1) / 256)}); win_q.push_back({1'b1, 8'((H - 1) % 256)});
        win_q.push_back({1'b0, 8'h2C});

        rst = 1'b0;
        repeat (3) @(posedge clk_out);
        @(negedge clk_out);
        check_reset_outputs("reset");
        @(posedge clk_out);
        #1 rst = 1'b1;

        wait_bytes(18, 3000, "init_seq");
        for (int i = 0; i < 7; i++)
            check($sformatf("init_byte%0d", i), 32'(rx[i]), 32'(init_q[i]));
        for (int i = 0; i < 11; i++)
            check($sformatf("win_byte%0d", i), 32'(rx[7 + i]), 32'(win_q[i]));
        check("cs_hi_after_swreset", 32'(cs_run_at[1] >= DLY), 32'd1);
        check("cs_hi_after_slpout",  32'(cs_run_at[2] >= DLY), 32'd1);

        base_cs = cs_high_total;
        wait_bytes(18 + 16, 1000, "stream_f800");
        for (int k = 0; k < 4; k++) begin
            check($sformatf("f800_hi%0d", k), 32'(rx[18 + 2 * k]), 32'h1F8);
            check($sformatf("f800_lo%0d", k), 32'(rx[19 + 2 * k]), 32'h100);
        end
        for (int i = 1; i < 8; i++)
            check($sformatf("dclk_period%0d", i), 32'(dclk_t[i] - dclk_t[i - 1]), 32'd32);
        check("cs_low_stream", 32'(cs_high_total), 32'(base_cs));
        check("dclk_one_cycle", 32'(dclk_wide), 32'd0);

        mode = 1;
        wait_bytes(nbytes + 60, 2500, "stream_random");

        wait_pin(1'b0, 100, "dclk_before_pause");
        repeat ($urandom_range(1, 30)) @(negedge clk_out);
        d_snap = n_dclk;
        frame_done = 1'b1;
        wait_pin(1'b1, 100, "pause_cs");
        repeat (3) @(negedge clk_out);
        check("no_dclk_after_frame_done", 32'(n_dclk), 32'(d_snap));
        pb = nbytes;
        check("pixel_complete", 32'((pb - 18) % 2), 32'd0);
        npix = (pb - 18) / 2;
        check("pixel_count", 32'(npix), 32'(exp_pix.size()));
        for (int k = 0; k < npix; k++)
            check($sformatf("pixel_seq%0d", k), 32'({rx[18 + 2 * k], rx[19 + 2 * k]}),
                  32'({1'b1, exp_pix[k][15:8], 1'b1, exp_pix[k][7:0]}));
        repeat (40) @(negedge clk_out);
        check("pause_no_dclk", 32'(n_dclk), 32'(d_snap));
        check("pause_cs_high", 32'(spi_cs), 32'd1);
        check("pause_no_bytes", 32'(nbytes), 32'(pb));

        frame_done = 1'b0;
        wait_bytes(pb + 11 + 8, 1000, "resume");
        for (int i = 0; i < 11; i++)
            check($sformatf("resume_win%0d", i), 32'(rx[pb + i]), 32'(win_q[i]));
        for (int j = 0; j < 4; j++)
            check($sformatf("resume_pix%0d", j), 32'({rx[pb + 11 + 2 * j], rx[pb + 12 + 2 * j]}),
                  32'({1'b1, exp_pix[npix + j][15:8], 1'b1, exp_pix[npix + j][7:0]}));

        wait_pin(1'b0, 100, "dclk_before_reset");
        repeat ($urandom_range(2, 20)) @(posedge clk_out);
        #1 rst = 1'b0;
        @(posedge clk_out);
        @(negedge clk_out);
        check_reset_outputs("midrst");
        @(posedge clk_out);
        #1 rst = 1'b1;
        rb = nbytes;
        wait_bytes(rb + 2, 600, "reinit");
        check("reinit_byte0", 32'(rx[rb]), 32'h001);
        check("reinit_byte1", 32'(rx[rb + 1]), 32'h011);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ili9341_spi_driver.md
# ili9341_spi_driver

Drives an ILI9341 TFT panel over a 4-wire write-only SPI link (MOSI, SCK, CS, D/C). After reset it runs the panel power-up command sequence and programs a full-screen address window. It then streams 16-bit RGB565 pixels supplied by the upstream frame generator. It sits between the system clock divider (`freq_divider`, which produces `clk_out`) and the display pins, and paces the upstream pixel source through `data_clk`.

## Interface
- `CLK_HZ`, 62_500_000 — frequency of `clk_out`; used only to derive the default delays.
- `WIDTH`, 240 — columns in the address window.
- `HEIGHT`, 240 — rows in the address window.
- `SWRESET_DLY`, CLK_HZ/200 — wait after SWRESET, in cycles (5 ms).
- `SLPOUT_DLY`, CLK_HZ/8 — wait after SLPOUT, in cycles (125 ms).

Ports:
- `clk_out`  in  1  — block clock; all logic runs on its rising edge.
- `rst`  in  1  — synchronous, active-low reset (rst = 0 resets).
- `frame_done`  in  1  — high: upstream frame complete, pause streaming; low: stream pixels.
- `input_data`  in  16  — RGB565 pixel, sampled when `data_clk` pulses.
- `spi_mosi`  out  1  — serial data, MSB first.
- `spi_sck`  out  1  — SPI clock, mode 0, `clk_out`/2.
- `spi_cs`  out  1  — chip select, active low.
- `spi_dc`  out  1  — 0 = command byte, 1 = parameter or pixel data.
- `data_clk`  out  1  — one-cycle-high pixel request/strobe; the upstream uses it as a clock.

## Operation
- Reset values: `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0, `spi_dc`=0, `data_clk`=0. The FSM goes to INIT and the ROM index is 0. Reset mid-transfer aborts immediately with no partial-byte completion.
- FSM states: INIT → DELAY → INIT … → WINDOW → STREAM ⇄ PAUSE → WINDOW.
- INIT walks a fixed ROM of {dc, byte, delay-flag} entries. The bytes are sent in this order:
  - 0x01 (delay SWRESET_DLY)
  - 0x11 (delay SLPOUT_DLY)
  - 0x3A, 0x55
  - 0x36, 0x48
  - 0x29
- DELAY raises `spi_cs` and counts the selected number of cycles. It then returns to INIT at the next entry.
- WINDOW sends the following bytes, then enters STREAM:
  - 0x2A (cmd), 0x00, 0x00, (WIDTH-1)>>8, (WIDTH-1)&0xFF
  - 0x2B (cmd), 0x00, 0x00, (HEIGHT-1)>>8, (HEIGHT-1)&0xFF
  - 0x2C (cmd)
- STREAM, once per pixel:
  - latch `input_data` and pulse `data_clk` for one cycle;
  - shift the latched pixel high byte then low byte with `spi_dc`=1.
- STREAM repeats while `frame_done`=0. The pixel counter wraps at WIDTH*HEIGHT without any action; the panel auto-wraps.
- If `frame_done`=1 at a pixel boundary, the current pixel is completed, then the FSM enters PAUSE with `spi_cs`=1 and `data_clk` held at 0.
- PAUSE waits for `frame_done`=0, then goes to WINDOW. Re-sending the window restarts the panel at pixel (0,0).
- Only STREAM pulses `data_clk`.

## Timing
- One bit takes 2 cycles:
  - SCK-low phase: `spi_mosi` and `spi_dc` change;
  - SCK-high phase: the panel samples.
- One byte takes 16 cycles; consecutive bytes within a state are back-to-back.
- `spi_cs` falls one cycle before the first SCK-low phase of a burst. It rises one cycle after the last SCK-high phase of a burst.
- `spi_cs` stays low from the first byte of WINDOW through all of STREAM.
- Pixel period is exactly 32 cycles, with no gap between pixels.
- `data_clk` is high in the first cycle of each pixel period; `input_data` is latched on that same edge.
- The upstream update on the `data_clk` edge is used for the next pixel, giving 31 cycles of setup margin.
- `frame_done` is sampled only at pixel boundaries, i.e. the last cycle of a pixel.

## Structure
- Shared package holds:
  - ILI9341 command constants: SWRESET, SLPOUT, COLMOD, MADCTL, DISPON, CASET, PASET, RAMWR;
  - the FSM state enum.
- One natural sub-module, `spi_byte_tx`. It accepts a byte and dc with a start pulse, generates SCK/MOSI, and returns `done`. The top FSM owns CS, the ROM, the delay counter and the pixel pacing.

## Test plan
- Reset: hold rst=0 for 3 cycles → `spi_cs`=1, `spi_sck`=0, `spi_mosi`=0, `spi_dc`=0, `data_clk`=0.
- Init sequence with SWRESET_DLY=10, SLPOUT_DLY=10: decode MOSI on SCK rising edges.
  - Bytes must be 01,11,3A,55,36,48,29,2A,00,00,00,EF,2B,00,00,00,EF,2C.
  - dc must be 0 only on 01,11,3A,36,29,2A,2B,2C.
  - `spi_cs` must be high for at least 10 cycles after 01 and after 11.
- Pixel stream with `input_data`=0xF800, `frame_done`=0:
  - decoded data bytes are F8,00 with dc=1;
  - `data_clk` pulses exactly every 32 cycles;
  - `spi_cs` stays low.
- Pixel sequence: upstream increments `input_data` on each `data_clk` edge → successive pixels are transmitted in order with no loss or duplication.
- Pause and resume:
  - `frame_done`=1 mid-pixel → that pixel completes, then `spi_cs`=1 and no further `data_clk`;
  - `frame_done`=0 → 2A,00,00,00,EF,2B,00,00,00,EF,2C is re-sent, then streaming resumes.
- Reset mid-stream: rst=0 during a pixel → outputs return to reset values next edge; after release the full init sequence restarts from 01.
